vc_input_buffer: RTL and testbench

- Router input-port buffer holding NUM_VC independent virtual-channel FIFOs of DEPTH flits each.
- Supersedes the single-queue fifo at router input ports.
- Adds per-VC addressing, show-ahead heads for all VCs at once, per-VC occupancy and credit-return pulses for upstream flow control, and sticky overflow/underflow error flags.
- Sits between the link receiver and the route-compute/VC-allocation stage.

---
 rtl/noc_pkg.sv | 16 +
 rtl/vc_lane.sv | 73 +++++++
 rtl/vc_input_buffer.sv | 96 +++++++++
 tb/tb_vc_input_buffer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and default sizing for the router input-port buffering.
package noc_pkg;

  localparam int DEFAULT_DEPTH      = 5;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_VC     = 2;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [DEFAULT_DATA_WIDTH-1:0]        flit_t;
  typedef logic [idx_width(DEFAULT_NUM_VC)-1:0] vc_id_t;

endpackage

// File: rtl/vc_lane.sv
// Single virtual-channel circular buffer with show-ahead head, occupancy
// count and a registered credit pulse for every accepted pop.
module vc_lane
  import noc_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_en,
  input  logic                  pop_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  credit
);

  localparam int PTR_W = idx_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  credit_reg;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_en) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop_en)  rd_ptr_next = ptr_inc(rd_ptr_reg);
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      credit_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      credit_reg <= pop_en;
    end
  end

  // Storage is deliberately left out of reset; head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= din;
  end

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CNT_W'(DEPTH));
  assign count  = count_reg;
  assign credit = credit_reg;
  assign head   = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/vc_input_buffer.sv
// Router input-port buffer: NUM_VC independent show-ahead VC FIFOs with
// per-VC status, credit return and sticky overflow/underflow flags.
module vc_input_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_VC     = DEFAULT_NUM_VC,
  parameter int VC_W       = idx_width(NUM_VC),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [VC_W-1:0]              push_vc,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         pop,
  input  logic [VC_W-1:0]              pop_vc,
  output logic [NUM_VC*DATA_WIDTH-1:0] head,
  output logic [NUM_VC-1:0]            empty,
  output logic [NUM_VC-1:0]            full,
  output logic [NUM_VC*CNT_W-1:0]      count,
  output logic [NUM_VC-1:0]            credit_out,
  output logic                         overflow_err,
  output logic                         underflow_err
);

  logic              push_vc_ok, pop_vc_ok;
  logic              push_tgt_full, pop_src_empty;
  logic              push_ok, pop_ok;
  logic [NUM_VC-1:0] push_en, pop_en;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;

  // Only a non-power-of-two VC count can produce an unused index.
  if (NUM_VC == (1 << VC_W)) begin : g_vc_pow2
    assign push_vc_ok = 1'b1;
    assign pop_vc_ok  = 1'b1;
  end else begin : g_vc_npow2
    assign push_vc_ok = (int'(push_vc) < NUM_VC);
    assign pop_vc_ok  = (int'(pop_vc) < NUM_VC);
  end

  always_comb begin
    push_tgt_full = 1'b1;
    pop_src_empty = 1'b1;
    if (push_vc_ok) push_tgt_full = full[push_vc];
    if (pop_vc_ok)  pop_src_empty = empty[pop_vc];
  end

  // A full VC still accepts a write when it is being drained in the same cycle.
  assign pop_ok  = pop && pop_vc_ok && !pop_src_empty;
  assign push_ok = push && push_vc_ok &&
                   (!push_tgt_full || (pop_ok && (pop_vc == push_vc)));

  always_comb begin
    overflow_next  = overflow_reg  | (push && !push_ok);
    underflow_next = underflow_reg | (pop && !pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign overflow_err  = overflow_reg;
  assign underflow_err = underflow_reg;

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_lane
    assign push_en[gi] = push_ok && (push_vc == VC_W'(gi));
    assign pop_en[gi]  = pop_ok  && (pop_vc  == VC_W'(gi));

    vc_lane #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .push_en (push_en[gi]),
      .pop_en  (pop_en[gi]),
      .din     (din),
      .head    (head[gi*DATA_WIDTH +: DATA_WIDTH]),
      .empty   (empty[gi]),
      .full    (full[gi]),
      .count   (count[gi*CNT_W +: CNT_W]),
      .credit  (credit_out[gi])
    );
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Scoreboard bench for vc_input_buffer: stimulus queues timed expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_vc_input_buffer;

  localparam int DW     = 32;
  localparam int DEPTH  = 5;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;
  localparam int CNT_W  = 3;

  localparam int K_HEAD   = 0;
  localparam int K_CNT    = 1;
  localparam int K_EMPTY  = 2;
  localparam int K_FULL   = 3;
  localparam int K_CREDIT = 4;
  localparam int K_OVF    = 5;
  localparam int K_UNF    = 6;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     push;
  logic [VC_W-1:0]          push_vc;
  logic [DW-1:0]            din;
  logic                     pop;
  logic [VC_W-1:0]          pop_vc;
  logic [NUM_VC*DW-1:0]     head;
  logic [NUM_VC-1:0]        empty;
  logic [NUM_VC-1:0]        full;
  logic [NUM_VC*CNT_W-1:0]  count;
  logic [NUM_VC-1:0]        credit_out;
  logic                     overflow_err;
  logic                     underflow_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          at;
    int          kind;
    int          vc;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];

  vc_input_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .NUM_VC     (NUM_VC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_vc       (push_vc),
    .din           (din),
    .pop           (pop),
    .pop_vc        (pop_vc),
    .head          (head),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .credit_out    (credit_out),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind, input int vc);
    logic [31:0] r;
    r = '0;
    case (kind)
      K_HEAD:   r = head[vc*DW +: DW];
      K_CNT:    r = 32'(count[vc*CNT_W +: CNT_W]);
      K_EMPTY:  r = 32'(empty);
      K_FULL:   r = 32'(full);
      K_CREDIT: r = 32'(credit_out);
      K_OVF:    r = 32'(overflow_err);
      K_UNF:    r = 32'(underflow_err);
      default:  r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: consume every expectation due in the current cycle.
  always @(negedge clk) begin : monitor
    int i;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].at == cyc) begin
        check(sbq[i].name, actual(sbq[i].kind, sbq[i].vc), sbq[i].val);
        sbq.delete(i);
      end else if (sbq[i].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never checked", sbq[i].name, sbq[i].at);
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  // Expectation for the state visible after the next rising edge.
  task automatic exp1(input string nm, input int kind, input int vc, input logic [31:0] v);
    exp_t e;
    e.at   = cyc + 1;
    e.kind = kind;
    e.vc   = vc;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic pu, input int pvc, input logic [31:0] d,
                       input logic po, input int povc);
    push    = pu;
    push_vc = VC_W'(pvc);
    din     = d;
    pop     = po;
    pop_vc  = VC_W'(povc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    drive(1'b0, 0, '0, 1'b0, 0);
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"},  actual(K_EMPTY, 0),  32'h3);
    check({tag, "_full"},   actual(K_FULL, 0),   32'h0);
    check({tag, "_count0"}, actual(K_CNT, 0),    32'h0);
    check({tag, "_count1"}, actual(K_CNT, 1),    32'h0);
    check({tag, "_credit"}, actual(K_CREDIT, 0), 32'h0);
    check({tag, "_ovf"},    actual(K_OVF, 0),    32'h0);
    check({tag, "_unf"},    actual(K_UNF, 0),    32'h0);
  endtask

  // Let pending checks retire, assert reset between edges, then release.
  task automatic do_reset(input string tag);
    idle_tick();
    idle_tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_state(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 0, '0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    reset = 1'b0;

    // Test 1: idle after reset
    exp1("t1_empty", K_EMPTY, 0, 32'h3);
    exp1("t1_full", K_FULL, 0, 32'h0);
    exp1("t1_count0", K_CNT, 0, 0);
    exp1("t1_credit", K_CREDIT, 0, 0);
    exp1("t1_ovf", K_OVF, 0, 0);
    exp1("t1_unf", K_UNF, 0, 0);
    exp1("t1_head0", K_HEAD, 0, 0);
    idle_tick();

    // Test 2: fill VC0, then overflow
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 0, 32'(i), 1'b0, 0);
      exp1("t2_count0", K_CNT, 0, 32'(i));
      exp1("t2_head0", K_HEAD, 0, 1);
      tick();
    end
    drive(1'b1, 0, 32'd6, 1'b0, 0);
    exp1("t2_full_pre", K_FULL, 0, 32'h1);
    exp1("t2_empty_pre", K_EMPTY, 0, 32'h2);
    tick();
    idle_tick();
    exp1("t2_ovf", K_OVF, 0, 1);
    exp1("t2_head0_keep", K_HEAD, 0, 1);
    exp1("t2_count0_keep", K_CNT, 0, 5);
    exp1("t2_full", K_FULL, 0, 32'h1);
    exp1("t2_count1", K_CNT, 1, 0);
    idle_tick();
    exp1("t2_ovf_sticky", K_OVF, 0, 1);
    idle_tick();

    // Test 3: push+pop on full VC0, then drain
    do_reset("t3_rst");
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 0, 32'(i), 1'b0, 0);
      tick();
    end
    drive(1'b1, 0, 32'd6, 1'b1, 0);
    exp1("t3_full", K_FULL, 0, 32'h1);
    exp1("t3_head0", K_HEAD, 0, 2);
    exp1("t3_count0", K_CNT, 0, 5);
    exp1("t3_credit", K_CREDIT, 0, 32'h1);
    exp1("t3_ovf", K_OVF, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 0, '0, 1'b1, 0);
      exp1("t3_drain_head0", K_HEAD, 0, (i == 4) ? 32'd0 : 32'(3 + i));
      exp1("t3_drain_count0", K_CNT, 0, 32'(4 - i));
      exp1("t3_drain_credit", K_CREDIT, 0, 32'h1);
      tick();
    end
    drive(1'b0, 0, '0, 1'b0, 0);
    exp1("t3_empty", K_EMPTY, 0, 32'h3);
    exp1("t3_credit_off", K_CREDIT, 0, 32'h0);
    exp1("t3_unf", K_UNF, 0, 0);
    tick();

    // Test 4: VC1 push while popping VC0
    drive(1'b1, 0, 32'd1, 1'b0, 0);
    tick();
    drive(1'b1, 0, 32'd2, 1'b0, 0);
    tick();
    drive(1'b1, 1, 32'hA0, 1'b1, 0);
    exp1("t4_head1", K_HEAD, 1, 32'hA0);
    exp1("t4_head0", K_HEAD, 0, 2);
    exp1("t4_count0", K_CNT, 0, 1);
    exp1("t4_count1", K_CNT, 1, 1);
    exp1("t4_credit", K_CREDIT, 0, 32'h1);
    tick();

    // Test 5: steady push+pop on VC1 across several pointer wraps
    for (int j = 0; j < 12; j++) begin
      drive(1'b1, 1, 32'(10 + j), 1'b1, 1);
      exp1("t5_head1", K_HEAD, 1, 32'(10 + j));
      exp1("t5_count1", K_CNT, 1, 1);
      exp1("t5_credit", K_CREDIT, 0, 32'h2);
      tick();
    end
    drive(1'b0, 0, '0, 1'b1, 1);
    exp1("t5_drain_empty", K_EMPTY, 0, 32'h2);
    exp1("t5_head0", K_HEAD, 0, 2);
    tick();

    // Test 6: pop on empty VC1 with concurrent push, then async reset
    drive(1'b1, 1, 32'h55, 1'b1, 1);
    exp1("t6_unf", K_UNF, 0, 1);
    exp1("t6_count1", K_CNT, 1, 1);
    exp1("t6_head1", K_HEAD, 1, 32'h55);
    exp1("t6_credit", K_CREDIT, 0, 32'h0);
    exp1("t6_ovf", K_OVF, 0, 0);
    tick();
    drive(1'b1, 0, 32'h77, 1'b0, 0);
    tick();
    drive(1'b1, 1, 32'h88, 1'b1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("t6_async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_tick();
    idle_tick();

    if (sbq.size() != 0) begin
      foreach (sbq[k]) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d left pending", sbq[k].name, sbq[k].at);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
